// File: rtl/muladd_rslt_q.sv
// Result queue and issue-credit gate behind the fixed-latency multiply-add pipe.
// Credits guarantee every in-flight result has a free FIFO slot on arrival.
module muladd_rslt_q #(
  parameter int DEPTH  = 32,
  parameter int LAT    = 20,
  parameter int HTID_W = 7
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              i_issue,
  output logic              o_issue_rdy,
  input  logic              i_vld,
  input  logic [HTID_W-1:0] i_htId,
  input  logic [63:0]       i_res,
  output logic              o_vld,
  output logic [HTID_W-1:0] o_htId,
  output logic [63:0]       o_res,
  input  logic              i_rdy,
  output logic              o_ovfl
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(LAT + 2);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [FW-1:0] LAT_C  = FW'(LAT);

  typedef struct packed {
    logic [HTID_W-1:0] ht;
    logic [63:0]       res;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, cred_q, cred_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          ovfl_q, ovfl_d;
  logic          flush_done, push, pop, full, wr_en, issue_acc;

  // The pipe has no reset, so anything arriving during the flush window is stale.
  assign flush_done = (flush_q == '0);
  assign full       = (cnt_q == FULL_C);
  assign push       = i_vld & flush_done;
  assign pop        = o_vld & i_rdy;
  assign wr_en      = push & (~full | pop);
  assign issue_acc  = i_issue & o_issue_rdy;

  assign o_issue_rdy = (cred_q != '0) & flush_done;
  assign o_vld       = (cnt_q != '0);
  assign o_htId      = mem_q[rd_q].ht;
  assign o_res       = mem_q[rd_q].res;
  assign o_ovfl      = ovfl_q;

  always_comb begin
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d    = pop   ? rd_q + AW'(1) : rd_q;
    flush_d = flush_done ? flush_q : flush_q - FW'(1);
    ovfl_d  = ovfl_q | (push & full & ~pop);

    cnt_d = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Saturate at DEPTH so pops of injected (uncredited) entries cannot wrap.
    cred_d = cred_q;
    if (issue_acc && !pop)
      cred_d = cred_q - CW'(1);
    else if (pop && !issue_acc && cred_q != FULL_C)
      cred_d = cred_q + CW'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cred_q  <= FULL_C;
      flush_q <= LAT_C;
      ovfl_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cred_q  <= cred_d;
      flush_q <= flush_d;
      ovfl_q  <= ovfl_d;
    end
  end

  always_ff @(posedge ck) begin
    if (wr_en) mem_q[wr_q] <= '{ht: i_htId, res: i_res};
  end

endmodule

// File: tb/tb_muladd_rslt_q.sv
// Scoreboard bench: a queue-based model of the result FIFO, credits and flush
// window, fed by a behavioural fixed-latency pipe.
module tb_muladd_rslt_q;
  localparam int DEPTH = 32;
  localparam int LAT   = 20;
  localparam int HW    = 7;

  logic          ck = 1'b0, rst_n = 1'b0;
  logic          i_issue = 1'b0, i_vld = 1'b0, i_rdy = 1'b0;
  logic [HW-1:0] i_htId = '0;
  logic [63:0]   i_res = '0;
  logic          o_issue_rdy, o_vld, o_ovfl;
  logic [HW-1:0] o_htId;
  logic [63:0]   o_res;

  int checks = 0, errors = 0;

  always #5 ck = ~ck;

  muladd_rslt_q #(.DEPTH(DEPTH), .LAT(LAT), .HTID_W(HW)) dut (
    .ck(ck), .rst_n(rst_n), .i_issue(i_issue), .o_issue_rdy(o_issue_rdy),
    .i_vld(i_vld), .i_htId(i_htId), .i_res(i_res),
    .o_vld(o_vld), .o_htId(o_htId), .o_res(o_res),
    .i_rdy(i_rdy), .o_ovfl(o_ovfl)
  );

  typedef struct packed {
    logic [HW-1:0] ht;
    logic [63:0]   res;
  } ent_t;

  // stimulus controls (sequencer-owned)
  logic          iss_en = 0, rdy_en = 0, rnd = 0, junk = 0, inj = 0, frc = 0;
  logic [HW-1:0] inj_ht = '0, frc_ht = '0;
  logic [63:0]   inj_res = '0, frc_res = '0;
  int            cyc = 0;

  // model state (monitor-owned)
  ent_t q[$];
  ent_t pipe_d [64];
  bit   pipe_v [64];
  int   m_cr = DEPTH, m_fl = LAT, tag = 0, acc_cnt = 0, pop_cnt = 0;
  bit   m_ovfl = 0, m_rdy, m_pop, m_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ck);
    #1;
    cyc++;
    i_issue = rnd ? 1'($urandom_range(0, 1)) : iss_en;
    i_rdy   = rnd ? 1'($urandom_range(0, 1)) : rdy_en;
    if (pipe_v[cyc % 64]) begin
      i_vld = 1'b1; i_htId = pipe_d[cyc % 64].ht; i_res = pipe_d[cyc % 64].res;
    end else if (inj) begin
      i_vld = 1'b1; i_htId = inj_ht; i_res = inj_res;
    end else if (junk) begin
      i_vld = 1'b1; i_htId = HW'($urandom); i_res = {$urandom, $urandom};
    end else begin
      i_vld = 1'b0; i_htId = HW'($urandom); i_res = {$urandom, $urandom};
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle.
  initial forever begin
    @(negedge ck);
    pipe_v[cyc % 64] = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_cr = DEPTH; m_fl = LAT; m_ovfl = 0; tag = 0; acc_cnt = 0; pop_cnt = 0;
    end else begin
      m_rdy = (m_cr != 0) && (m_fl == 0);
      chk("o_vld", 64'(o_vld), 64'(q.size() != 0));
      chk("o_issue_rdy", 64'(o_issue_rdy), 64'(m_rdy));
      chk("o_ovfl", 64'(o_ovfl), 64'(m_ovfl));
      chk("credits", 64'(dut.cred_q), 64'(m_cr));
      if (q.size() != 0 && o_vld) begin
        chk("head_htId", 64'(o_htId), 64'(q[0].ht));
        chk("head_res", o_res, q[0].res);
      end
      m_pop = (q.size() != 0) && i_rdy;
      if (m_pop) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      if (i_vld && m_fl == 0) begin
        if (q.size() < DEPTH) q.push_back('{ht: i_htId, res: i_res});
        else m_ovfl = 1;
      end
      m_acc = i_issue && m_rdy;
      if (m_acc) begin
        acc_cnt++;
        pipe_v[(cyc + LAT) % 64] = 1'b1;
        if (frc) pipe_d[(cyc + LAT) % 64] = '{ht: frc_ht, res: frc_res};
        else begin
          pipe_d[(cyc + LAT) % 64] = '{ht: tag[HW-1:0], res: {$urandom, $urandom}};
          tag++;
        end
      end
      m_cr = m_cr + int'(m_pop) - int'(m_acc);
      if (m_cr > DEPTH) m_cr = DEPTH;
      if (m_cr < 0) begin
        m_cr = 0;
        chk("credit_underflow", 64'(1), 64'(0));
      end
      if (m_fl > 0) m_fl--;
    end
  end

  initial begin
    int a0, lo_rdy, lo_vld;
    repeat (3) tick();
    chk("rst_o_vld", 64'(o_vld), 64'(0));
    chk("rst_issue_rdy", 64'(o_issue_rdy), 64'(0));
    chk("rst_o_ovfl", 64'(o_ovfl), 64'(0));

    // flush window with junk on i_vld
    junk = 1;
    tick();
    rst_n = 1'b1;
    repeat (19) tick();
    chk("flush_rdy_19", 64'(o_issue_rdy), 64'(0));
    junk = 0;
    tick();
    chk("flush_rdy_20", 64'(o_issue_rdy), 64'(1));
    chk("flush_no_push", 64'(o_vld), 64'(0));

    // single op with known payload
    frc = 1; frc_ht = 7'd5; frc_res = 64'h0000_0001_0000_0002; iss_en = 1;
    tick();
    iss_en = 0;
    repeat (20) tick();
    frc = 0;
    chk("single_not_yet", 64'(o_vld), 64'(0));
    tick();
    chk("single_vld", 64'(o_vld), 64'(1));
    chk("single_htId", 64'(o_htId), 64'(5));
    chk("single_res", o_res, 64'h0000_0001_0000_0002);
    rdy_en = 1;
    tick();
    rdy_en = 0;
    tick();
    chk("single_cred_back", 64'(dut.cred_q), 64'(DEPTH));

    // credit exhaustion: consumer stalled, issue held high
    a0 = acc_cnt;
    iss_en = 1;
    repeat (40) tick();
    chk("exhaust_accepted", 64'(acc_cnt - a0), 64'(DEPTH));
    chk("exhaust_rdy_low", 64'(o_issue_rdy), 64'(0));
    iss_en = 0;
    repeat (LAT + 2) tick();
    chk("exhaust_full", 64'(dut.cnt_q), 64'(DEPTH));
    chk("exhaust_head0", 64'(o_htId), 64'(0));

    // full FIFO: push and pop in the same cycle
    inj = 1; inj_ht = 7'h55; inj_res = {$urandom, $urandom}; rdy_en = 1;
    tick();
    inj = 0; rdy_en = 0;
    tick();
    chk("fullpp_occ", 64'(dut.cnt_q), 64'(DEPTH));
    chk("fullpp_ovfl", 64'(o_ovfl), 64'(0));
    chk("fullpp_head", 64'(o_htId), 64'(1));

    // forced overflow, bypassing credits
    inj = 1; inj_ht = 7'h66; inj_res = {$urandom, $urandom};
    tick();
    inj = 0;
    tick();
    chk("ovfl_set", 64'(o_ovfl), 64'(1));
    repeat (5) tick();
    chk("ovfl_sticky", 64'(o_ovfl), 64'(1));
    chk("ovfl_occ", 64'(dut.cnt_q), 64'(DEPTH));
    chk("ovfl_head", 64'(o_htId), 64'(1));
    rdy_en = 1;
    repeat (10) tick();

    // asynchronous reset mid-stream
    iss_en = 1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_vld", 64'(o_vld), 64'(0));
    chk("midrst_rdy", 64'(o_issue_rdy), 64'(0));
    chk("midrst_ovfl", 64'(o_ovfl), 64'(0));
    iss_en = 0; rdy_en = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (LAT) tick();
    chk("midrst_flushed_empty", 64'(o_vld), 64'(0));

    // full-rate streaming
    lo_rdy = 0; lo_vld = 0;
    iss_en = 1; rdy_en = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (k >= LAT + 2) begin
        if (!o_issue_rdy) lo_rdy++;
        if (!o_vld) lo_vld++;
      end
    end
    chk("stream_rdy_drops", 64'(lo_rdy), 64'(0));
    chk("stream_vld_gaps", 64'(lo_vld), 64'(0));
    iss_en = 0;
    repeat (LAT + 5) tick();

    // random traffic
    rnd = 1;
    repeat (1500) tick();
    rnd = 0; iss_en = 0; rdy_en = 1;
    repeat (LAT + DEPTH + 5) tick();
    chk("final_empty", 64'(o_vld), 64'(0));
    chk("final_ovfl", 64'(o_ovfl), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muladd_rslt_q.md
Name: muladd_rslt_q

Overview:
- Result queue and issue-credit controller directly downstream of the 64-bit fixed-latency multiply-add pipeline (res = a + b*c, 20 cycles, no backpressure).
- Captures every valid result with its htId into a FIFO.
- Presents the results on a ready/valid interface to the thread return logic.
- Gates new issues into the pipeline with a credit counter, so a result can never arrive at a full queue.

Parameters:
- DEPTH, 32, result FIFO entries; power of 2, >= 2; full issue rate requires DEPTH >= LAT+1.
- LAT, 20, multiply-add pipeline latency in cycles; also the length of the post-reset flush window.
- HTID_W, 7, thread id width.

Ports:
- ck  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_issue  in  1  upstream presents an op to the multiply-add pipeline this cycle
- o_issue_rdy  out  1  a credit is available; an issue is accepted when i_issue && o_issue_rdy
- i_vld  in  1  result valid from pipeline
- i_htId  in  HTID_W  result thread id from pipeline
- i_res  in  64  result value from pipeline
- o_vld  out  1  queue head valid
- o_htId  out  HTID_W  queue head thread id
- o_res  out  64  queue head value
- i_rdy  in  1  consumer accepts head; pop when o_vld && i_rdy
- o_ovfl  out  1  sticky error: push attempted while FIFO full

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr/rd pointers 0, occupancy 0, credits = DEPTH, flush counter = LAT, o_ovfl 0.
  - Outputs during reset: o_vld 0, o_issue_rdy 0.
  - o_htId/o_res are don't-care whenever o_vld is 0.
- Flush window: the pipeline has no reset.
  - For LAT cycles after rst_n deasserts, the flush counter decrements once per cycle.
  - While the counter is non-zero: i_vld is ignored (no push) and o_issue_rdy = 0.
  - On the cycle the counter reaches 0, normal operation begins.
- Credits (width clog2(DEPTH+1)):
  - Accepted issue: -1.
  - Pop: +1.
  - Both in the same cycle: unchanged.
  - o_issue_rdy = (credits != 0) && flush done; driven from registers only, with no combinational path from i_issue.
  - i_issue while o_issue_rdy = 0 is not accepted; upstream holds or drops per its own rules.
  - Credits never exceed DEPTH and never go below 0. The bench asserts both.
- FIFO:
  - Push on i_vld when flush is done; stores {i_htId, i_res} at wr pointer, and the pointer wraps modulo DEPTH.
  - Pop advances the rd pointer.
  - o_vld = (occupancy != 0); o_htId/o_res read the rd-pointer entry (registered storage, combinational read).
  - No bypass: a push into an empty FIFO makes o_vld = 1 on the next cycle, so minimum residency is 1 cycle.
  - Simultaneous push and pop: occupancy unchanged; legal at full (pop frees a slot in the same cycle) and at empty (pop not possible since o_vld = 0; push only).
- Overflow (push while occupancy == DEPTH with no pop):
  - The data is dropped and o_ovfl sets.
  - o_ovfl stays set until reset.
  - Unreachable when credit rules are obeyed.
- Ordering: results leave in arrival order, which equals issue order because pipeline latency is fixed.
- End-to-end latency: issue at cycle t gives a push at t+LAT and o_vld at t+LAT+1 if the queue is empty.
- Reset mid-operation: all queued entries and in-flight credits are discarded. Results still in the pipeline are absorbed by the flush window.

Test Plan:
- Post-reset flush: release rst_n and drive i_vld = 1 with junk for 20 cycles. Required: no push, o_vld 0, o_issue_rdy 0 for cycles 0..19, and o_issue_rdy 1 on cycle 20.
- Single op: issue once; 20 cycles later push htId = 5, res = 0x0000_0001_0000_0002. Required: o_vld 1 one cycle later with those values; credits back to 32 after pop with i_rdy = 1.
- Credit exhaustion: i_rdy = 0 and i_issue held high. Required: exactly 32 issues accepted and o_issue_rdy 0 after the 32nd. The 32 results fill the FIFO without setting o_ovfl; raising i_rdy returns them in htId order 0..31.
- Full-rate streaming: i_issue and i_rdy high continuously for 200 cycles with DEPTH 32. Required: o_issue_rdy never drops after the pipeline fills, and 1 result per cycle in order.
- Full with simultaneous push/pop: FIFO at 32, i_vld and i_rdy both high. Required: occupancy stays 32, o_ovfl stays 0, and the head advances.
- Forced overflow: bypass credits, push a 33rd entry with no pop. Required: o_ovfl 1 and sticky, and the stored 32 entries are unchanged. Then assert reset mid-stream: all outputs return to reset values immediately.
